// File: rtl/aes_pkg.sv
// aes_pkg -- shared AES datapath definitions.
//
// Holds the GF(2^8) reduction constant, the byte/column/state typedefs
// and the small constant multipliers used by the MixColumns stages.
// Every multiplier is built from xtime chains, so no lookup tables are
// inferred anywhere that imports this package.
//
// Column and state vectors use ascending ranges. Byte k of a state
// therefore occupies bits [8k:8k+7], and bit 0 is the MSB of byte 0.
package aes_pkg;

  localparam logic [7:0] AES_POLY_RED = 8'h1B;

  typedef logic [7:0]   aes_byte_t;
  typedef logic [0:31]  aes_col_t;
  typedef logic [0:127] aes_state_t;

  // Multiply by x (i.e. by 2) in GF(2^8), reducing by the AES polynomial.
  function automatic aes_byte_t xtime(input aes_byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? AES_POLY_RED : 8'h00);
  endfunction

  function automatic aes_byte_t gf_mul2(input aes_byte_t b);
    return xtime(b);
  endfunction

  function automatic aes_byte_t gf_mul3(input aes_byte_t b);
    return xtime(b) ^ b;
  endfunction

  // The inverse coefficients are all sums of b, 2b, 4b and 8b.
  function automatic aes_byte_t gf_mul9(input aes_byte_t b);
    aes_byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ b;
  endfunction

  function automatic aes_byte_t gf_mulb(input aes_byte_t b);
    aes_byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x2 ^ b;
  endfunction

  function automatic aes_byte_t gf_muld(input aes_byte_t b);
    aes_byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ b;
  endfunction

  function automatic aes_byte_t gf_mule(input aes_byte_t b);
    aes_byte_t x2, x4, x8;
    x2 = xtime(b);
    x4 = xtime(x2);
    x8 = xtime(x4);
    return x8 ^ x4 ^ x2;
  endfunction

endpackage

// File: rtl/mix_column_word.sv
// mix_column_word -- combinational MixColumns for a single 4-byte column.
//
// Optional feature macro: MIX_COLUMNS_INV_EN (adds the inv input and the
// InvMixColumns matrix).
//
// Ports:
//   col_in   input  [0:31]  column, row 0 in bits [0:7]
//   inv      input  1       (MIX_COLUMNS_INV_EN only) 1 selects inverse
//   col_out  output [0:31]  transformed column, same byte ordering
module mix_column_word
  import aes_pkg::*;
(
  input  aes_col_t col_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic     inv,
`endif
  output aes_col_t col_out
);

  aes_byte_t a0, a1, a2, a3;
  aes_byte_t f0, f1, f2, f3;

  assign a0 = col_in[0:7];
  assign a1 = col_in[8:15];
  assign a2 = col_in[16:23];
  assign a3 = col_in[24:31];

  // Forward matrix rows are {2,3,1,1} rotated right by one per row.
  assign f0 = gf_mul2(a0) ^ gf_mul3(a1) ^ a2          ^ a3;
  assign f1 = a0          ^ gf_mul2(a1) ^ gf_mul3(a2) ^ a3;
  assign f2 = a0          ^ a1          ^ gf_mul2(a2) ^ gf_mul3(a3);
  assign f3 = gf_mul3(a0) ^ a1          ^ a2          ^ gf_mul2(a3);

`ifdef MIX_COLUMNS_INV_EN
  aes_byte_t i0, i1, i2, i3;

  // Inverse matrix rows are {E,B,D,9} rotated right by one per row.
  assign i0 = gf_mule(a0) ^ gf_mulb(a1) ^ gf_muld(a2) ^ gf_mul9(a3);
  assign i1 = gf_mul9(a0) ^ gf_mule(a1) ^ gf_mulb(a2) ^ gf_muld(a3);
  assign i2 = gf_muld(a0) ^ gf_mul9(a1) ^ gf_mule(a2) ^ gf_mulb(a3);
  assign i3 = gf_mulb(a0) ^ gf_muld(a1) ^ gf_mul9(a2) ^ gf_mule(a3);

  assign col_out = inv ? {i0, i1, i2, i3} : {f0, f1, f2, f3};
`else
  assign col_out = {f0, f1, f2, f3};
`endif

endmodule

// File: rtl/mix_columns.sv
// mix_columns -- registered AES MixColumns round stage.
//
// All four columns are transformed in parallel and the result is
// registered, giving a fixed one-cycle latency with no backpressure.
//
// Optional feature macro: MIX_COLUMNS_INV_EN (adds the inv port; inv=1
// selects InvMixColumns).
//
// Ports:
//   clk        input  1        rising-edge clock
//   rst_n      input  1        synchronous active-low reset
//   in_valid   input  1        data_in is valid this cycle
//   data_in    input  [0:127]  state in, byte k at bits [8k:8k+7]
//   inv        input  1        (MIX_COLUMNS_INV_EN only) inverse select
//   out_valid  output 1        data_out holds a new result
//   data_out   output [0:127]  transformed state, same byte ordering
module mix_columns
  import aes_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  input  aes_state_t data_in,
`ifdef MIX_COLUMNS_INV_EN
  input  logic       inv,
`endif
  output logic       out_valid,
  output aes_state_t data_out
);

  aes_state_t mixed;

  for (genvar c = 0; c < 4; c++) begin : g_col
    mix_column_word u_word (
      .col_in  (data_in[32*c +: 32]),
`ifdef MIX_COLUMNS_INV_EN
      .inv     (inv),
`endif
      .col_out (mixed[32*c +: 32])
    );
  end

  // data_out holds its last result across idle cycles; only out_valid drops.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      data_out  <= mixed;
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_mix_columns.sv
// tb_mix_columns -- self-checking bench for mix_columns.
//
// The reference model multiplies each column by the AES matrix using a
// generic shift-and-add GF(2^8) multiply and a coefficient table, and
// tracks the register's expected reset/hold behaviour cycle by cycle.
// Build with MIX_COLUMNS_INV_EN defined to also exercise the inverse.
module tb_mix_columns;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic [0:127] data_in;
  logic         inv;
  logic         out_valid;
  logic [0:127] data_out;

  logic [0:127] exp_data;
  logic         exp_valid;
  int           checks;
  int           failures;

  mix_columns dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .data_in   (data_in),
`ifdef MIX_COLUMNS_INV_EN
    .inv       (inv),
`endif
    .out_valid (out_valid),
    .data_out  (data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) multiply: add shifted copies of a, reducing as we go.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] y;
    p = 8'h00;
    x = a;
    y = b;
    for (int i = 0; i < 8; i++) begin
      if (y[0]) p = p ^ x;
      x = x[7] ? ((x << 1) ^ 8'h1B) : (x << 1);
      y = y >> 1;
    end
    return p;
  endfunction

  // Matrix-times-column for every column; row r uses base[(j - r) mod 4].
  function automatic logic [0:127] ref_mix(input logic [0:127] s, input logic use_inv);
    logic [7:0]   base [4];
    logic [7:0]   acc;
    logic [0:127] r;
    if (use_inv) begin
      base[0] = 8'h0E; base[1] = 8'h0B; base[2] = 8'h0D; base[3] = 8'h09;
    end else begin
      base[0] = 8'h02; base[1] = 8'h03; base[2] = 8'h01; base[3] = 8'h01;
    end
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int j = 0; j < 4; j++)
          acc = acc ^ gmul(base[(j - row + 4) % 4], s[8*(4*c+j) +: 8]);
        r[8*(4*c+row) +: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [0:127] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Drive one cycle of inputs away from the edge, then update the model.
  task automatic applyStimulus(input logic rst_v, input logic v,
                               input logic [0:127] d, input logic i);
    @(negedge clk);
    rst_n    = rst_v;
    in_valid = v;
    data_in  = d;
    inv      = i;
    @(posedge clk);
    #1;
    if (!rst_v) begin
      exp_data  = '0;
      exp_valid = 1'b0;
    end else if (v) begin
      exp_data  = ref_mix(d, i);
      exp_valid = 1'b1;
    end else begin
      exp_valid = 1'b0;
    end
  endtask

  task automatic checkOutput(input string tag, input logic [0:127] want_data,
                             input logic want_valid);
    checks++;
    assert (data_out === want_data) else begin
      failures++;
      $error("[TB] FAIL %s data_out observed=%h expected=%h", tag, data_out, want_data);
    end
    checks++;
    assert (out_valid === want_valid) else begin
      failures++;
      $error("[TB] FAIL %s out_valid observed=%b expected=%b", tag, out_valid, want_valid);
    end
  endtask

  initial begin
    logic         rv, vv, iv;
    logic [0:127] d;
    checks    = 0;
    failures  = 0;
    exp_data  = '0;
    exp_valid = 1'b0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    data_in   = '0;
    inv       = 1'b0;

    // Reset state.
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    applyStimulus(1'b0, 1'b0, '0, 1'b0);
    checkOutput("reset", 128'h0, 1'b0);

    // Single known vector; one-cycle latency.
    applyStimulus(1'b1, 1'b1, 128'h6353e08c0960e104cd70b751bacad0e7, 1'b0);
    checkOutput("vec1", 128'h5f72641557f5bc92f7be3b291db9f91a, 1'b1);

    // Back-to-back inputs, one result per cycle.
    applyStimulus(1'b1, 1'b1, 128'ha7be1a6997ad739bd8c9ca451f618b61, 1'b0);
    checkOutput("b2b0", 128'hff87968431d86a51645151fa773ad009, 1'b1);
    applyStimulus(1'b1, 1'b1, 128'h3bd92268fc74fb735767cbe0c0590e2d, 1'b0);
    checkOutput("b2b1", 128'h4c9c1e66f771f0762c3f868e534df256, 1'b1);
    applyStimulus(1'b1, 1'b1, 128'h54d990a16ba09ab596bbf40ea111702f, 1'b0);
    checkOutput("b2b2", 128'he9f74eec023020f61bf2ccf2353c21c7, 1'b1);

    // Hold on idle: data stays, valid drops.
    applyStimulus(1'b1, 1'b1, 128'he8dab6901477d4653ff7f5e2e747dd4f, 1'b0);
    checkOutput("hold_load", 128'h9816ee7400f87f556b2c049c8e5ad036, 1'b1);
    applyStimulus(1'b1, 1'b0, 128'h0123456789abcdef0123456789abcdef, 1'b0);
    checkOutput("hold_idle1", 128'h9816ee7400f87f556b2c049c8e5ad036, 1'b0);
    applyStimulus(1'b1, 1'b0, 128'hfedcba9876543210fedcba9876543210, 1'b0);
    checkOutput("hold_idle2", 128'h9816ee7400f87f556b2c049c8e5ad036, 1'b0);

    // Reset beats a simultaneous valid input.
    applyStimulus(1'b0, 1'b1, 128'hb458124c68b68a014b99f82e5f15554c, 1'b0);
    checkOutput("rst_prio", 128'h0, 1'b0);
    applyStimulus(1'b1, 1'b1, 128'hb458124c68b68a014b99f82e5f15554c, 1'b0);
    checkOutput("post_rst", 128'hc57e1c159a9bd286f05f4be098c63439, 1'b1);

    // Boundary patterns.
    applyStimulus(1'b1, 1'b1, 128'h0, 1'b0);
    checkOutput("zeros", 128'h0, 1'b1);
    applyStimulus(1'b1, 1'b1, {16{8'h01}}, 1'b0);
    checkOutput("ones01", {16{8'h01}}, 1'b1);

`ifdef MIX_COLUMNS_INV_EN
    applyStimulus(1'b1, 1'b1, 128'h5f72641557f5bc92f7be3b291db9f91a, 1'b1);
    checkOutput("inv_vec", 128'h6353e08c0960e104cd70b751bacad0e7, 1'b1);
`endif

    // Randomized traffic against the model, with occasional idle and reset.
    for (int n = 0; n < 60; n++) begin
      rv = ($urandom_range(0, 9) != 0);
      vv = ($urandom_range(0, 3) != 0);
      d  = rand128();
`ifdef MIX_COLUMNS_INV_EN
      iv = $urandom_range(0, 1) == 1;
`else
      iv = 1'b0;
`endif
      applyStimulus(rv, vv, d, iv);
      checkOutput("random", exp_data, exp_valid);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
